regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_if.sv | 34 +++
 rtl/regfile_write_arbiter.sv | 83 ++++++++
 tb/tb_regfile_write_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Handshake and write-port bundle between two write requesters, the arbiter
// and a 32x32 register file.
// Ports: ReqA_*/ReqB_* valid/register/data/ready per requester;
//        RegWrite/WriteRegister/WriteData register-file write port; Busy init flag.
interface regfile_write_arbiter_if;
  logic        ReqA_Valid;
  logic [4:0]  ReqA_Register;
  logic [31:0] ReqA_Data;
  logic        ReqA_Ready;
  logic        ReqB_Valid;
  logic [4:0]  ReqB_Register;
  logic [31:0] ReqB_Data;
  logic        ReqB_Ready;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        Busy;

  // Arbiter side.
  modport slave (
    input  ReqA_Valid, ReqA_Register, ReqA_Data,
    input  ReqB_Valid, ReqB_Register, ReqB_Data,
    output ReqA_Ready, ReqB_Ready,
    output RegWrite, WriteRegister, WriteData, Busy
  );

  // Requester / register-file side.
  modport master (
    output ReqA_Valid, ReqA_Register, ReqA_Data,
    output ReqB_Valid, ReqB_Register, ReqB_Data,
    input  ReqA_Ready, ReqB_Ready,
    input  RegWrite, WriteRegister, WriteData, Busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging two register-file write requesters onto one
// registered write port (one cycle latency, one write per cycle, reg 0 dropped).
// Ports: Clk, Reset (async, active-high), bus (regfile_write_arbiter_if.slave).
// Optional macro REGFILE_ARB_INIT_EN: after reset, write INIT_DATA to regs 1..31
// (31 cycles, Busy=1, requests ignored) before arbitration starts.
module regfile_write_arbiter #(
  parameter logic [31:0] INIT_DATA = 32'd0
) (
  input logic                    Clk,
  input logic                    Reset,
  regfile_write_arbiter_if.slave bus
);

  logic        ptr_b;      // 1: requester B wins a tie, 0: requester A wins
  logic        arb_active;
  logic        grant_a;
  logic        grant_b;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;

`ifdef REGFILE_ARB_INIT_EN
  typedef enum logic {ST_INIT, ST_ARB} state_t;
  state_t     state;
  logic [4:0] init_cnt;

  assign arb_active = (state == ST_ARB);
`else
  assign arb_active = 1'b1;
`endif

  assign bus.Busy = ~arb_active;

  // A lone valid always wins; on a tie the pointer decides.
  always_comb begin
    grant_a = arb_active & bus.ReqA_Valid & (~bus.ReqB_Valid | ~ptr_b);
    grant_b = arb_active & bus.ReqB_Valid & (~bus.ReqA_Valid |  ptr_b);
  end

  assign bus.ReqA_Ready = grant_a;
  assign bus.ReqB_Ready = grant_b;
  assign sel_reg        = grant_b ? bus.ReqB_Register : bus.ReqA_Register;
  assign sel_data       = grant_b ? bus.ReqB_Data     : bus.ReqA_Data;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      // Clearing the write port also discards an accepted-but-unwritten request.
      bus.RegWrite      <= 1'b0;
      bus.WriteRegister <= 5'd0;
      bus.WriteData     <= 32'd0;
      ptr_b             <= 1'b0;
`ifdef REGFILE_ARB_INIT_EN
      state             <= ST_INIT;
      init_cnt          <= 5'd1;
`endif
    end else begin
      bus.RegWrite <= 1'b0;
`ifdef REGFILE_ARB_INIT_EN
      if (state == ST_INIT) begin
        bus.RegWrite      <= 1'b1;
        bus.WriteRegister <= init_cnt;
        bus.WriteData     <= INIT_DATA;
        init_cnt          <= init_cnt + 5'd1;
        // Arbitration opens in the same cycle reg 31 is on the write port.
        if (init_cnt == 5'd31) begin
          state <= ST_ARB;
        end
      end
`endif
      // Grants are gated off during init, so this never collides with it.
      if (grant_a | grant_b) begin
        ptr_b <= grant_a;
        // Reg 0 handshakes complete but are not forwarded; the write port
        // address/data keep their previous values.
        if (sel_reg != 5'd0) begin
          bus.RegWrite      <= 1'b1;
          bus.WriteRegister <= sel_reg;
          bus.WriteData     <= sel_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

`ifdef REGFILE_ARB_INIT_EN
  localparam logic [31:0] BG       = 32'hA5;  // register contents after init
  localparam logic        BUSY_RST = 1'b1;
`else
  localparam logic [31:0] BG       = 32'd0;
  localparam logic        BUSY_RST = 1'b0;
`endif

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_err;

  regfile_write_arbiter_if bus();

  regfile_write_arbiter #(.INIT_DATA(32'hA5)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // 32x32 register file driven by the arbiter's write port; reg 0 reads 0.
  logic [31:0] rf [32];
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;

  always @(posedge Clk) begin
    if (bus.RegWrite && bus.WriteRegister != 5'd0) begin
      rf[bus.WriteRegister] <= bus.WriteData;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : rf[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : rf[ra2];

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : rf[a];
  endfunction

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.ReqA_Valid = v; bus.ReqA_Register = r; bus.ReqA_Data = d;
  endtask

  task automatic set_b(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.ReqB_Valid = v; bus.ReqB_Register = r; bus.ReqB_Data = d;
  endtask

  task automatic wait_init();
`ifdef REGFILE_ARB_INIT_EN
    for (int i = 0; i < 31; i++) begin
      #1;
      check("init_busy", {31'd0, bus.Busy}, 32'd1);
      check("init_rdy_a", {31'd0, bus.ReqA_Ready}, 32'd0);
      check("init_rdy_b", {31'd0, bus.ReqB_Ready}, 32'd0);
      step();
      check("init_we", {31'd0, bus.RegWrite}, 32'd1);
      check("init_wr", {27'd0, bus.WriteRegister}, i + 1);
      check("init_wd", bus.WriteData, 32'hA5);
    end
    #1;
    check("init_busy_done", {31'd0, bus.Busy}, 32'd0);
`endif
  endtask

  initial begin
    int ka, kb;
    bit exp_a;
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    ra1 = 5'd0;
    ra2 = 5'd0;
    Reset = 1'b1;
    // Contention: both requesters valid from reset.
    set_a(1'b1, 5'd4, 32'd22);
    set_b(1'b1, 5'd9, 32'd55);
    #12;
    check("rst_we", {31'd0, bus.RegWrite}, 32'd0);
    check("rst_wr", {27'd0, bus.WriteRegister}, 32'd0);
    check("rst_wd", bus.WriteData, 32'd0);
    check("rst_busy", {31'd0, bus.Busy}, {31'd0, BUSY_RST});
    step();
    Reset = 1'b0;
    wait_init();
    #1;
    check("cont_rdy_a", {31'd0, bus.ReqA_Ready}, 32'd1);
    check("cont_rdy_b", {31'd0, bus.ReqB_Ready}, 32'd0);
    step();
`ifdef REGFILE_ARB_INIT_EN
    for (int r = 1; r < 32; r++) check("init_reg", rf_read(r[4:0]), 32'hA5);
    check("init_reg0", rf_read(5'd0), 32'd0);
`endif
    check("cont_we_a", {31'd0, bus.RegWrite}, 32'd1);
    check("cont_wr_a", {27'd0, bus.WriteRegister}, 32'd4);
    check("cont_wd_a", bus.WriteData, 32'd22);
    set_a(1'b0, 5'd0, 32'd0);
    #1;
    check("cont_rdy_b2", {31'd0, bus.ReqB_Ready}, 32'd1);
    step();
    check("cont_wr_b", {27'd0, bus.WriteRegister}, 32'd9);
    check("cont_wd_b", bus.WriteData, 32'd55);
    set_b(1'b0, 5'd0, 32'd0);
    step();
    check("idle_we", {31'd0, bus.RegWrite}, 32'd0);
    check("idle_wr_hold", {27'd0, bus.WriteRegister}, 32'd9);
    check("idle_wd_hold", bus.WriteData, 32'd55);
    check("cont_reg4", rf_read(5'd4), 32'd22);
    check("cont_reg9", rf_read(5'd9), 32'd55);
    check("cont_reg5", rf_read(5'd5), BG);
    check("cont_reg8", rf_read(5'd8), BG);

    // Single write with both read ports on reg 2.
    set_a(1'b1, 5'd2, 32'd42);
    #1;
    check("single_rdy_a", {31'd0, bus.ReqA_Ready}, 32'd1);
    step();
    set_a(1'b0, 5'd0, 32'd0);
    check("single_we", {31'd0, bus.RegWrite}, 32'd1);
    check("single_wr", {27'd0, bus.WriteRegister}, 32'd2);
    check("single_wd", bus.WriteData, 32'd42);
    step();
    ra1 = 5'd2;
    ra2 = 5'd2;
    #1;
    check("single_rd1", rd1, 32'd42);
    check("single_rd2", rd2, 32'd42);

    // Fairness: pointer is now B (after A's single write); make it A first
    // by a lone B handshake so six contended grants start with A.
    set_b(1'b1, 5'd1, 32'd11);
    step();
    set_b(1'b0, 5'd0, 32'd0);
    ka = 0;
    kb = 0;
    for (int i = 0; i < 6; i++) begin
      set_a(1'b1, 5'(10 + ka), 32'(100 + ka));
      set_b(1'b1, 5'(20 + kb), 32'(200 + kb));
      #1;
      exp_a = (i % 2 == 0);
      check("fair_rdy_a", {31'd0, bus.ReqA_Ready}, {31'd0, exp_a});
      check("fair_rdy_b", {31'd0, bus.ReqB_Ready}, {31'd0, ~exp_a});
      if (i > 0) check("fair_we", {31'd0, bus.RegWrite}, 32'd1);
      step();
      if (exp_a) ka++; else kb++;
    end
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0);
    check("fair_we_last", {31'd0, bus.RegWrite}, 32'd1);
    check("fair_wr_last", {27'd0, bus.WriteRegister}, 32'd22);
    step();
    check("fair_we_off", {31'd0, bus.RegWrite}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      check("fair_reg_a", rf_read(5'(10 + k)), 32'(100 + k));
      check("fair_reg_b", rf_read(5'(20 + k)), 32'(200 + k));
    end

    // Zero register: A alone (pointer -> B), B to reg 0 (pointer -> A).
    set_a(1'b1, 5'd3, 32'd33);
    step();
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b1, 5'd0, 32'd82);
    #1;
    check("zero_rdy_b", {31'd0, bus.ReqB_Ready}, 32'd1);
    step();
    check("zero_we", {31'd0, bus.RegWrite}, 32'd0);
    set_a(1'b1, 5'd5, 32'd55);
    set_b(1'b1, 5'd6, 32'd66);
    #1;
    check("zero_next_rdy_a", {31'd0, bus.ReqA_Ready}, 32'd1);
    check("zero_next_rdy_b", {31'd0, bus.ReqB_Ready}, 32'd0);
    step();
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0);
    check("zero_next_wr", {27'd0, bus.WriteRegister}, 32'd5);
    ra1 = 5'd0;
    #1;
    check("zero_reg0", rd1, 32'd0);

    // Reset mid-burst: pointer is B, reg 7 write pending on the port.
    set_a(1'b1, 5'd7, 32'd82);
    step();
    set_a(1'b0, 5'd0, 32'd0);
    check("rb_we_pre", {31'd0, bus.RegWrite}, 32'd1);
    check("rb_wr_pre", {27'd0, bus.WriteRegister}, 32'd7);
    #2;
    Reset = 1'b1;
    #1;
    check("rb_we", {31'd0, bus.RegWrite}, 32'd0);
    check("rb_wr", {27'd0, bus.WriteRegister}, 32'd0);
    check("rb_wd", bus.WriteData, 32'd0);
    check("rb_busy", {31'd0, bus.Busy}, {31'd0, BUSY_RST});
    step();
    check("rb_reg7", rf_read(5'd7), BG);
    set_a(1'b1, 5'd8, 32'd88);
    set_b(1'b1, 5'd12, 32'd1);
    Reset = 1'b0;
    wait_init();
    #1;
    check("rb_rdy_a", {31'd0, bus.ReqA_Ready}, 32'd1);
    check("rb_rdy_b", {31'd0, bus.ReqB_Ready}, 32'd0);
    step();
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0);
    check("rb_wr_a", {27'd0, bus.WriteRegister}, 32'd8);
    check("rb_wd_a", bus.WriteData, 32'd88);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
